// File: rtl/fft_stage_seq.sv
// fft_stage_seq: one radix-2 DIT stage over a buffered frame, P butterflies per clock.
// Define FFT_STAGE_SCALE_EN to halve every output (floor) instead of saturating.
module fft_stage_seq #(
    parameter int N     = 8,
    parameter int P     = 2,
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int STAGE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*2*DW-1:0]     in_data,
    input  logic [(N/2)*2*TW-1:0] tw,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*2*DW-1:0]     out_data,
    output logic                  busy
);
    localparam int NB = N / (2 * P);
    localparam int CW = NB > 1 ? $clog2(NB) : 1;
    localparam int LN = $clog2(N);
    localparam int IW = LN;
    localparam int KW = LN - 1;
    localparam int S  = 1 << STAGE;
    localparam int PW = DW + TW + 1;
    localparam int SW = DW + 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] x [N];
    logic [2*DW-1:0] y [N];
    logic [2*TW-1:0] w [N/2];
    logic [IW-1:0]   top_i [P];
    logic [IW-1:0]   bot_i [P];
    logic [2*DW-1:0] y_top [P];
    logic [2*DW-1:0] y_bot [P];

    // Sums are kept wide so the final narrowing sees the true value.
    function automatic logic [DW-1:0] scale(input logic signed [SW-1:0] v);
`ifdef FFT_STAGE_SCALE_EN
        return DW'(v >>> 1);
`else
        return (&v[SW-1:DW-1] || ~|v[SW-1:DW-1]) ? v[DW-1:0] : {v[SW-1], {(DW-1){~v[SW-1]}}};
`endif
    endfunction

    for (genvar g = 0; g < N / 2; g++) begin : g_tw
        assign w[g] = tw[g*2*TW +: 2*TW];
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign out_data[g*2*DW +: 2*DW] = y[g];
    end

    for (genvar l = 0; l < P; l++) begin : g_lane
        logic [IW-1:0]        b;
        logic [KW-1:0]        k;
        logic signed [DW-1:0] xtr, xti, xbr, xbi;
        logic signed [TW-1:0] wr, wi;
        logic signed [PW-1:0] pr, pi;
        logic signed [SW-1:0] tr, ti;
        assign b = IW'(cnt) * IW'(P) + IW'(l);
        assign top_i[l] = ((b >> STAGE) << (STAGE + 1)) | (b & IW'(S - 1));
        assign bot_i[l] = top_i[l] + IW'(S);
        assign k = KW'((b & IW'(S - 1)) << (LN - 1 - STAGE));
        assign {xtr, xti} = x[top_i[l]];
        assign {xbr, xbi} = x[bot_i[l]];
        assign {wr, wi} = w[k];
        assign pr = PW'(xbr) * PW'(wr) - PW'(xbi) * PW'(wi);
        assign pi = PW'(xbr) * PW'(wi) + PW'(xbi) * PW'(wr);
        assign tr = SW'(pr >>> (TW - 2));
        assign ti = SW'(pi >>> (TW - 2));
        assign y_top[l] = {scale(SW'(xtr) + tr), scale(SW'(xti) + ti)};
        assign y_bot[l] = {scale(SW'(xtr) - tr), scale(SW'(xti) - ti)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < N; i++) y[i] <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int i = 0; i < N; i++) x[i] <= in_data[i*2*DW +: 2*DW];
                    cnt      <= '0;
                    state    <= RUN;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                RUN: begin
                    for (int i = 0; i < P; i++) begin
                        y[top_i[i]] <= y_top[i];
                        y[bot_i[i]] <= y_bot[i];
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NB - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
